// File: rtl/multi_debounce.sv
// N-channel switch/button debouncer: 2-flop synchroniser per channel, then a saturating
// stability counter that commits a new clean level and emits registered rise/fall pulses.
module multi_debounce #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned STABLE_COUNT = 4,
  parameter int unsigned RESET_VAL    = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_chg
);

  localparam int unsigned CW = $clog2(STABLE_COUNT);
  localparam logic [CW-1:0] TERM = CW'(STABLE_COUNT - 1);
  localparam logic [CHANNELS-1:0] RST_LVL = {CHANNELS{1'(RESET_VAL)}};

  logic [CHANNELS-1:0]         s1_q, s1_d;
  logic [CHANNELS-1:0]         s2_q, s2_d;
  logic [CHANNELS-1:0]         clean_q, clean_d;
  logic [CHANNELS-1:0]         rise_q, rise_d;
  logic [CHANNELS-1:0]         fall_q, fall_d;
  logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;
  logic                        any_chg_q, any_chg_d;

  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    clean_d = clean_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      // An agreeing sample aborts any pending change, independent of tick.
      if (s2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == TERM) begin
          clean_d[i] = s2_q[i];
          cnt_d[i]   = '0;
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    any_chg_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q      <= RST_LVL;
      s2_q      <= RST_LVL;
      clean_q   <= RST_LVL;
      cnt_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      any_chg_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      clean_q   <= clean_d;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      any_chg_q <= any_chg_d;
    end
  end

  assign clean   = clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign any_chg = any_chg_q;

endmodule
